cve2_wb_stage: RTL

Registered writeback stage between the ID/EX stage and the register file. It replaces the pure passthrough writeback with a single-entry pipeline register. The stage holds one retiring instruction and drives up to `NumWrPorts` register-file write ports. It stalls on outstanding load responses and optionally exposes the resident result for operand forwarding into ID. It also generates the retire/performance pulses at the true completion point.

---
 rtl/cve2_wb_stage_pkg.sv | 23 ++
 rtl/cve2_wb_stage_if.sv | 46 ++++
 rtl/cve2_wb_stage.sv | 94 +++++++++
 3 files changed

// File: rtl/cve2_wb_stage_pkg.sv
// cve2_wb_stage_pkg: shared types for the registered writeback stage
package cve2_wb_stage_pkg;

    // Upper bound on register-file write ports served by the stage
    localparam int MaxWrPorts = 2;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_DATA     = 2'd1,
        WB_WAIT_LSU = 2'd2
    } wb_state_e;

    // One resident instruction; arrays sized for the widest configuration
    typedef struct packed {
        logic [MaxWrPorts-1:0][4:0]  waddr;
        logic [MaxWrPorts-1:0][31:0] wdata;
        logic [MaxWrPorts-1:0]       we;
        logic                        load;
        logic                        compressed;
        logic                        perf;
    } wb_entry_t;

endpackage

// File: rtl/cve2_wb_stage_if.sv
// cve2_wb_stage_if: ID/LSU-facing and register-file-facing signals of the writeback stage
interface cve2_wb_stage_if #(
    parameter int NumWrPorts = 2
);
    logic                        en_wb_i;
    logic                        wb_ready_o;
    logic                        instr_is_load_id_i;
    logic                        instr_is_compressed_id_i;
    logic                        instr_perf_count_id_i;
    logic [NumWrPorts-1:0][4:0]  rf_waddr_id_i;
    logic [NumWrPorts-1:0][31:0] rf_wdata_id_i;
    logic [NumWrPorts-1:0]       rf_we_id_i;
    logic                        lsu_resp_valid_i;
    logic                        lsu_resp_err_i;
    logic [31:0]                 rf_wdata_lsu_i;
    logic [NumWrPorts-1:0][4:0]  rf_waddr_wb_o;
    logic [NumWrPorts-1:0][31:0] rf_wdata_wb_o;
    logic [NumWrPorts-1:0]       rf_we_wb_o;
    logic [NumWrPorts-1:0]       fwd_valid_o;
    logic [NumWrPorts-1:0][4:0]  fwd_waddr_o;
    logic [NumWrPorts-1:0][31:0] fwd_wdata_o;
    logic                        perf_instr_ret_wb_o;
    logic                        perf_instr_ret_compressed_wb_o;
    logic                        wb_lsu_err_o;

    // Environment side: ID stage, LSU and register file
    modport master (
        output en_wb_i, instr_is_load_id_i, instr_is_compressed_id_i, instr_perf_count_id_i,
        output rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
        output lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i,
        input  wb_ready_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
        input  fwd_valid_o, fwd_waddr_o, fwd_wdata_o,
        input  perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o, wb_lsu_err_o
    );

    // Writeback stage side
    modport slave (
        input  en_wb_i, instr_is_load_id_i, instr_is_compressed_id_i, instr_perf_count_id_i,
        input  rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
        input  lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i,
        output wb_ready_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
        output fwd_valid_o, fwd_waddr_o, fwd_wdata_o,
        output perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o, wb_lsu_err_o
    );

endinterface

// File: rtl/cve2_wb_stage.sv
// cve2_wb_stage: single-entry registered writeback stage; define CVE2_WB_FWD_EN to expose the resident result for forwarding
module cve2_wb_stage
    import cve2_wb_stage_pkg::*;
#(
    parameter int NumWrPorts = 2
) (
    input logic           clk_i,
    input logic           rst_ni,
    cve2_wb_stage_if.slave wb
);

    wb_state_e state;
    wb_entry_t entry;
    wb_entry_t entry_d;
    logic      capture;
    logic      resp_ok;
    logic      resp_err;
    logic      complete;
    logic [NumWrPorts-1:0][4:0]  waddr;
    logic [NumWrPorts-1:0][31:0] wdata;
    logic [NumWrPorts-1:0]       we;

    assign resp_ok       = (state == WB_WAIT_LSU) & wb.lsu_resp_valid_i & ~wb.lsu_resp_err_i;
    assign resp_err      = (state == WB_WAIT_LSU) & wb.lsu_resp_valid_i & wb.lsu_resp_err_i;
    assign complete      = (state == WB_DATA) | ((state == WB_WAIT_LSU) & wb.lsu_resp_valid_i);
    assign wb.wb_ready_o = (state != WB_WAIT_LSU) | wb.lsu_resp_valid_i;
    assign capture       = wb.en_wb_i & wb.wb_ready_o;

    // Entry to capture: x0 writes and the upper ports of loads are squashed here
    always_comb begin
        entry_d            = '0;
        entry_d.load       = wb.instr_is_load_id_i;
        entry_d.compressed = wb.instr_is_compressed_id_i;
        entry_d.perf       = wb.instr_perf_count_id_i;
        for (int p = 0; p < NumWrPorts; p++) begin
            entry_d.waddr[p] = wb.rf_waddr_id_i[p];
            entry_d.wdata[p] = wb.rf_wdata_id_i[p];
            entry_d.we[p]    = wb.rf_we_id_i[p] & (wb.rf_waddr_id_i[p] != 5'd0)
                               & ~(wb.instr_is_load_id_i & (p != 0));
        end
    end

    // Stage register and FSM; a capture in the completion cycle overrides the return to idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= WB_IDLE;
            entry <= '0;
        end else if (capture) begin
            state <= entry_d.load ? WB_WAIT_LSU : WB_DATA;
            entry <= entry_d;
        end else if (complete) begin
            state <= WB_IDLE;
        end
    end

    // Register-file writes come only from the stage register and the LSU response
    always_comb begin
        for (int p = 0; p < NumWrPorts; p++) begin
            waddr[p] = ((state == WB_DATA) | (resp_ok & (p == 0))) ? entry.waddr[p] : 5'd0;
            wdata[p] = (state == WB_DATA) ? entry.wdata[p] :
                       (resp_ok & (p == 0)) ? wb.rf_wdata_lsu_i : 32'd0;
            we[p]    = ((state == WB_DATA) | (resp_ok & (p == 0))) & entry.we[p];
        end
    end

    assign wb.rf_waddr_wb_o                  = waddr;
    assign wb.rf_wdata_wb_o                  = wdata;
    assign wb.rf_we_wb_o                     = we;
    assign wb.perf_instr_ret_wb_o            = complete & entry.perf & ~resp_err;
    assign wb.perf_instr_ret_compressed_wb_o = complete & entry.perf & ~resp_err & entry.compressed;
    assign wb.wb_lsu_err_o                   = resp_err;

`ifdef CVE2_WB_FWD_EN
    assign wb.fwd_valid_o = we;
    assign wb.fwd_waddr_o = waddr;
    assign wb.fwd_wdata_o = wdata;
`else
    assign wb.fwd_valid_o = '0;
    assign wb.fwd_waddr_o = '0;
    assign wb.fwd_wdata_o = '0;
`endif

    // An LSU response is only expected while a load is resident
    a_stray_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wb.lsu_resp_valid_i |-> state == WB_WAIT_LSU);

    if (NumWrPorts == 2) begin : g_dual
        // Two enabled ports of one instruction must target different registers
        a_dup_addr: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (capture & ~wb.instr_is_load_id_i & wb.rf_we_id_i[0] & wb.rf_we_id_i[1])
            |-> wb.rf_waddr_id_i[0] != wb.rf_waddr_id_i[1]);
    end

endmodule
